ahb_apb_bridge: RTL and testbench
=================================

Name: ahb_apb_bridge

Overview:
- AHB-Lite slave to APB master bridge; one clock domain (APB runs on hclk_i).
- Each accepted AHB beat (single or burst beat) becomes exactly one APB SETUP/ACCESS transfer.
- hready_o/hreadyout_o are held low until APB completes.
- Contains a 2-flop reset-deassertion synchronizer so internal state leaves reset cleanly.

Parameters:
- ADDR_WIDTH, 32, address width of haddr_i/paddr_o
- HBURST_WIDTH, 3, hburst_i width
- HPROT_WIDTH, 4, hprot_i width
- DATA_WIDTH, 32, data width; byte strobes are DATA_WIDTH/8

Ports:
- hclk_i in 1 clock, all logic on rising edge
- hresetn_i in 1 async active-low reset
- haddr_i in ADDR_WIDTH AHB address
- hburst_i in HBURST_WIDTH burst type (ignored; each beat independent)
- hmastlock_i in 1 locked transfer (ignored)
- hsel_i in 1 slave select
- hprot_i in HPROT_WIDTH protection (ignored)
- hsize_i in 3 transfer size (ignored; must be ≤ DATA_WIDTH)
- hnonsec_i in 1 non-secure (ignored)
- hexcl_i in 1 exclusive request (ignored)
- hmaster_i in 1 master id (ignored)
- htrans_i in 2 IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
- hwdata_i in DATA_WIDTH write data (data phase)
- hwstrb_i in DATA_WIDTH/8 write byte strobes
- hwrite_i in 1 1=write
- hrdata_o out DATA_WIDTH read data
- hready_o out 1 bus ready; equals hreadyout_o (bridge is sole slave)
- hreadyout_o out 1 slave ready
- hresp_o out 1 0=OKAY 1=ERROR
- hexokay_o out 1 exclusive okay; constant 0
- paddr_o out ADDR_WIDTH APB address
- psel_o out 1 APB select
- penable_o out 1 APB enable
- pwrite_o out 1 APB direction
- pstrb_o out DATA_WIDTH/8 APB write strobes
- pwdata_o out DATA_WIDTH APB write data
- prdata_i in DATA_WIDTH APB read data
- pready_i in 1 APB ready

Behaviour:
- Reset: hresetn_i low asserts the internal reset immediately; release is synchronized through 2 hclk_i flops. State and outputs under reset:
  - FSM = IDLE
  - hready_o = hreadyout_o = 1
  - hresp_o = 0, hexokay_o = 0
  - hrdata_o = 0
  - psel_o = penable_o = pwrite_o = 0
  - paddr_o = pstrb_o = pwdata_o = 0
- Reset mid-transfer aborts the transfer: psel_o drops in the same cycle as the reset assertion.
- Accept condition: hsel_i & hready_o & htrans_i[1]. On accept, register haddr_i to paddr_o and hwrite_i to pwrite_o.
- IDLE or BUSY with hsel_i: zero-wait OKAY; FSM unchanged.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: on accept, go to SETUP.
- SETUP:
  - psel_o = 1, penable_o = 0, hready_o = 0.
  - Register hwdata_i and hwstrb_i; during SETUP, pwdata_o and pstrb_o are driven combinationally from hwdata_i and hwstrb_i, and from the registers afterwards.
  - Always go to ACCESS next.
- ACCESS:
  - psel_o = 1, penable_o = 1.
  - While pready_i = 0: hready_o = 0; stay in ACCESS; all P outputs stable.
  - When pready_i = 1: hready_o = 1 in the same cycle and hrdata_o = prdata_i (combinational).
  - If a new beat is accepted in that cycle, go to SETUP (back-to-back); otherwise go to IDLE and drop psel_o.
- hrdata_o holds its last completed read value otherwise.
- Latency: address phase at T0, SETUP at T1, ACCESS at T2. Minimum data phase is 2 cycles (1 wait state). Each pready_i low cycle adds one wait state.
- Burst types (INCR/WRAP): the master supplies every address; no address generation inside the bridge.
- Without PSLVERR_EN, hresp_o is constant 0.

Optional Feature:
- Macro PSLVERR_EN.
- Defined:
  - Adds port pslverr_i (in, 1, APB slave error).
  - ACCESS with pready_i & pslverr_i goes to state ERR instead of completing OKAY. In that cycle hresp_o = 1, hready_o = 0.
  - ERR lasts one cycle with hresp_o = 1, hready_o = 1, then returns to IDLE. A beat accepted during ERR is treated as in IDLE (goes to SETUP).
- Undefined: no pslverr_i port; hresp_o tied 0; no ERR state.

Decomposition:
- Package ahb_apb_pkg: HTRANS codes, HBURST codes, HRESP codes, FSM state enum (IDLE, SETUP, ACCESS, ERR).
- One sub-module rst_sync_2ff: async assert, 2-flop synchronized deassert of hresetn_i.
- Bridge FSM and datapath stay in the top module.

Test Plan:
- Reset: hold hresetn_i low → all outputs at reset values. Release → hready_o = 1, psel_o = 0; first accept possible 2 cycles after release.
- Single write: NONSEQ write to 0x0000_002C, hwdata 0xA5A5_1234, hwstrb 0xF, pready_i = 1 → T1 psel=1 penable=0; T2 penable=1 with paddr 0x2C and pwdata 0xA5A5_1234; hready_o high only at T2.
- Single read with 2 pready_i low cycles, prdata_i = 0xDEAD_BEEF → hready_o low for 3 data-phase cycles; hrdata_o = 0xDEAD_BEEF in the completing cycle; hresp_o = 0.
- WRAP8 word burst starting 0x2C (0x2C, 0x30…0x3C, 0x20…0x28) with back-to-back beats → 8 APB transfers with these paddr values in order; SETUP directly follows each ACCESS; no IDLE gap.
- IDLE/BUSY htrans with hsel_i = 1 → no psel_o assertion; hready_o stays 1.
- PSLVERR_EN: pslverr_i = 1 with pready_i = 1 on a write → hresp_o = 1 for two cycles, hready_o = 0 then 1, FSM returns to IDLE.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - AHB/APB bus codes and bridge FSM state type
package ahb_apb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ERR    = 2'd3
  } state_t;
endpackage

// File: rtl/rst_sync_2ff.sv
// rtl/rst_sync_2ff.sv - active-low reset, asynchronous assert, 2-flop synchronized release
module rst_sync_2ff (
  input  logic clk,
  input  logic rst_n_async,
  output logic rst_n_sync
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n_async) begin
    if (!rst_n_async) begin
      meta       <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      meta       <= 1'b1;
      rst_n_sync <= meta;
    end
  end
endmodule

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-Lite slave to APB master bridge; PSLVERR_EN adds APB slave error reporting
module ahb_apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int HBURST_WIDTH = 3,
  parameter int HPROT_WIDTH  = 4,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                    hclk_i,
  input  logic                    hresetn_i,
  input  logic [ADDR_WIDTH-1:0]   haddr_i,
  input  logic [HBURST_WIDTH-1:0] hburst_i,
  input  logic                    hmastlock_i,
  input  logic                    hsel_i,
  input  logic [HPROT_WIDTH-1:0]  hprot_i,
  input  logic [2:0]              hsize_i,
  input  logic                    hnonsec_i,
  input  logic                    hexcl_i,
  input  logic                    hmaster_i,
  input  logic [1:0]              htrans_i,
  input  logic [DATA_WIDTH-1:0]   hwdata_i,
  input  logic [DATA_WIDTH/8-1:0] hwstrb_i,
  input  logic                    hwrite_i,
  output logic [DATA_WIDTH-1:0]   hrdata_o,
  output logic                    hready_o,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  output logic                    hexokay_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
`ifdef PSLVERR_EN
  input  logic                    pslverr_i,
`endif
  input  logic                    pready_i
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  rst_n;
  state_t                state;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [STRB_WIDTH-1:0] strb_q;
  logic                  accept;
  logic                  complete;
  logic                  slv_err;
  logic                  unused_inputs;

  rst_sync_2ff u_rst_sync (
    .clk         (hclk_i),
    .rst_n_async (hresetn_i),
    .rst_n_sync  (rst_n)
  );

`ifdef PSLVERR_EN
  assign slv_err = pslverr_i;
  assign hresp_o = (complete && slv_err) || (state == ST_ERR);
`else
  assign slv_err = 1'b0;
  assign hresp_o = HRESP_OKAY;
`endif

  // Burst, protection and lock attributes carry no meaning for a one-beat-per-transfer APB bridge.
  assign unused_inputs = ^{hburst_i, hmastlock_i, hprot_i, hsize_i, hnonsec_i,
                           hexcl_i, hmaster_i, htrans_i[0]};

  assign complete  = (state == ST_ACCESS) && pready_i;
  assign accept    = hsel_i && hready_o && htrans_i[1];
  assign hready_o  = hreadyout_o;
  assign hexokay_o = 1'b0;
  assign psel_o    = (state == ST_SETUP) || (state == ST_ACCESS);
  assign penable_o = (state == ST_ACCESS);
  assign pwdata_o  = (state == ST_SETUP) ? hwdata_i : wdata_q;
  assign pstrb_o   = (state == ST_SETUP) ? hwstrb_i : strb_q;
  assign hrdata_o  = complete ? prdata_i : rdata_q;

  always_comb begin
    hreadyout_o = 1'b1;
    unique case (state)
      ST_SETUP:  hreadyout_o = 1'b0;
      ST_ACCESS: hreadyout_o = pready_i && !slv_err;
      default:   hreadyout_o = 1'b1;
    endcase
  end

  always_ff @(posedge hclk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      paddr_o  <= '0;
      pwrite_o <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
    end else begin
      if (accept) begin
        paddr_o  <= haddr_i;
        pwrite_o <= hwrite_i;
      end
      case (state)
        ST_IDLE, ST_ERR: state <= accept ? ST_SETUP : ST_IDLE;
        ST_SETUP: begin
          // Write data is only valid in the first data-phase cycle; hold it for ACCESS.
          wdata_q <= hwdata_i;
          strb_q  <= hwstrb_i;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready_i) begin
            if (slv_err) begin
              state <= ST_ERR;
            end else begin
              if (!pwrite_o) rdata_q <= prdata_i;
              state <= accept ? ST_SETUP : ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - randomized self-checking bench for ahb_apb_bridge with a beat-level bus model
module tb_ahb_apb_bridge;
  import ahb_apb_pkg::*;

  logic        hclk_i = 1'b0;
  logic        hresetn_i;
  logic [31:0] haddr_i;
  logic [2:0]  hburst_i;
  logic        hmastlock_i;
  logic        hsel_i;
  logic [3:0]  hprot_i;
  logic [2:0]  hsize_i;
  logic        hnonsec_i;
  logic        hexcl_i;
  logic        hmaster_i;
  logic [1:0]  htrans_i;
  logic [31:0] hwdata_i;
  logic [3:0]  hwstrb_i;
  logic        hwrite_i;
  logic [31:0] hrdata_o;
  logic        hready_o;
  logic        hreadyout_o;
  logic        hresp_o;
  logic        hexokay_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [3:0]  pstrb_o;
  logic [31:0] pwdata_o;
  logic [31:0] prdata_i;
  logic        pready_i;
`ifdef PSLVERR_EN
  logic        pslverr_i;
`endif

  always #5 hclk_i = ~hclk_i;

  ahb_apb_bridge dut (
    .hclk_i      (hclk_i),
    .hresetn_i   (hresetn_i),
    .haddr_i     (haddr_i),
    .hburst_i    (hburst_i),
    .hmastlock_i (hmastlock_i),
    .hsel_i      (hsel_i),
    .hprot_i     (hprot_i),
    .hsize_i     (hsize_i),
    .hnonsec_i   (hnonsec_i),
    .hexcl_i     (hexcl_i),
    .hmaster_i   (hmaster_i),
    .htrans_i    (htrans_i),
    .hwdata_i    (hwdata_i),
    .hwstrb_i    (hwstrb_i),
    .hwrite_i    (hwrite_i),
    .hrdata_o    (hrdata_o),
    .hready_o    (hready_o),
    .hreadyout_o (hreadyout_o),
    .hresp_o     (hresp_o),
    .hexokay_o   (hexokay_o),
    .paddr_o     (paddr_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pstrb_o     (pstrb_o),
    .pwdata_o    (pwdata_o),
    .prdata_i    (prdata_i),
`ifdef PSLVERR_EN
    .pslverr_i   (pslverr_i),
`endif
    .pready_i    (pready_i)
  );

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [1:0]  trans;
    int          gap;
    int          waits;
  } beat_t;

  int          checks = 0;
  int          failures = 0;
  beat_t       pend[$];
  logic [31:0] model_mem[16];
  logic [31:0] slave_mem[16];
  logic [31:0] last_read;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  task automatic add_beat(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [1:0] trans, input int gap,
                          input int waits);
    beat_t b;
    b.addr = addr; b.write = write; b.wdata = wdata; b.strb = strb;
    b.trans = trans; b.gap = gap; b.waits = waits;
    pend.push_back(b);
  endtask

  // Entered and left at posedge+1; acts as AHB master and APB slave, checking every cycle.
  task automatic run_beats(input int budget);
    beat_t       dp;
    bit          dp_active = 0;
    bit          exp_rdy;
    int          k = 0;
    int          cyc = 0;
    logic [31:0] exp_rd;
    dp = '{default: 0};
    while ((pend.size() > 0 || dp_active) && cyc < budget) begin
      if (dp_active) begin
        hwdata_i = (k == 0) ? dp.wdata : $urandom;
        hwstrb_i = (k == 0) ? dp.strb : 4'($urandom);
        pready_i = (k >= 1) && (k - 1 >= dp.waits);
      end else begin
        hwdata_i = $urandom;
        hwstrb_i = 4'($urandom);
        pready_i = 1'($urandom);
      end
      prdata_i = slave_mem[paddr_o[5:2]];
      if (pend.size() > 0 && pend[0].gap == 0) begin
        hsel_i = 1'b1; htrans_i = pend[0].trans; haddr_i = pend[0].addr; hwrite_i = pend[0].write;
      end else begin
        hsel_i = 1'($urandom); htrans_i = {1'b0, 1'($urandom)};
        haddr_i = $urandom; hwrite_i = 1'($urandom);
      end
      @(negedge hclk_i);
      exp_rdy = !dp_active || ((k >= 1) && pready_i);
      check("hready", hready_o, exp_rdy);
      check("hreadyout", hreadyout_o, exp_rdy);
      check("hresp", hresp_o, HRESP_OKAY);
      check("psel", psel_o, dp_active);
      if (dp_active) begin
        check("penable", penable_o, k >= 1);
        check("paddr", paddr_o, dp.addr);
        check("pwrite", pwrite_o, dp.write);
        check("pwdata", pwdata_o, dp.wdata);
        check("pstrb", pstrb_o, dp.strb);
        if (exp_rdy) begin
          if (!dp.write) begin
            exp_rd = model_mem[dp.addr[5:2]];
            check("hrdata", hrdata_o, exp_rd);
            last_read = exp_rd;
          end else begin
            model_mem[dp.addr[5:2]] = merge(model_mem[dp.addr[5:2]], dp.wdata, dp.strb);
          end
        end else begin
          check("hrdata_hold", hrdata_o, last_read);
        end
      end else begin
        check("penable_idle", penable_o, 1'b0);
        check("hrdata_hold", hrdata_o, last_read);
      end
      if (psel_o && penable_o && pready_i && pwrite_o)
        slave_mem[paddr_o[5:2]] = merge(slave_mem[paddr_o[5:2]], pwdata_o, pstrb_o);
      if (hready_o) begin
        dp_active = 0;
        if (hsel_i && htrans_i[1] && pend.size() > 0 && pend[0].gap == 0) begin
          dp = pend.pop_front();
          dp_active = 1;
          k = 0;
        end else if (pend.size() > 0 && pend[0].gap > 0) begin
          pend[0].gap = pend[0].gap - 1;
        end
      end else if (dp_active) begin
        k++;
      end
      @(posedge hclk_i); #1;
      cyc++;
    end
    check("run_budget", 32'(cyc < budget), 32'd1);
    pend.delete();
    hsel_i = 1'b0; htrans_i = HTRANS_IDLE;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hready"}, hready_o, 1'b1);
    check({tag, "_hreadyout"}, hreadyout_o, 1'b1);
    check({tag, "_hresp"}, hresp_o, 1'b0);
    check({tag, "_hexokay"}, hexokay_o, 1'b0);
    check({tag, "_hrdata"}, hrdata_o, 32'h0);
    check({tag, "_psel"}, psel_o, 1'b0);
    check({tag, "_penable"}, penable_o, 1'b0);
    check({tag, "_pwrite"}, pwrite_o, 1'b0);
    check({tag, "_paddr"}, paddr_o, 32'h0);
    check({tag, "_pstrb"}, pstrb_o, 4'h0);
    check({tag, "_pwdata"}, pwdata_o, 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] wrap_addr[8];
    hresetn_i = 1'b0; haddr_i = '0; hburst_i = HBURST_SINGLE; hmastlock_i = 1'b0;
    hsel_i = 1'b1; hprot_i = 4'h3; hsize_i = 3'd2; hnonsec_i = 1'b0; hexcl_i = 1'b0;
    hmaster_i = 1'b0; htrans_i = HTRANS_NONSEQ; hwdata_i = '0; hwstrb_i = '0;
    hwrite_i = 1'b1; prdata_i = '0; pready_i = 1'b1;
`ifdef PSLVERR_EN
    pslverr_i = 1'b0;
`endif
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = 32'h1000_0000 + i * 32'h0101_0101;
      slave_mem[i] = model_mem[i];
    end
    last_read = '0;

    // A NONSEQ request held during reset must not start a transfer.
    repeat (3) @(posedge hclk_i);
    @(negedge hclk_i);
    check_reset_outputs("rst");
    htrans_i = HTRANS_IDLE; hsel_i = 1'b0;
    hresetn_i = 1'b1;
    @(negedge hclk_i);
    check("rel_hready", hready_o, 1'b1);
    check("rel_psel", psel_o, 1'b0);
    @(posedge hclk_i); #1;

    add_beat(32'h2C, 1'b1, 32'hA5A5_1234, 4'hF, HTRANS_NONSEQ, 0, 0);
    add_beat(32'h2C, 1'b0, 32'h0, 4'h0, HTRANS_NONSEQ, 2, 2);
    add_beat(32'h08, 1'b1, 32'h1122_3344, 4'h0, HTRANS_NONSEQ, 3, 1);
    add_beat(32'h08, 1'b1, 32'h5566_7788, 4'h5, HTRANS_NONSEQ, 6, 0);
    add_beat(32'h08, 1'b0, 32'h0, 4'h0, HTRANS_NONSEQ, 0, 0);
    run_beats(200);

    hburst_i = HBURST_WRAP8;
    wrap_addr = '{32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h20, 32'h24, 32'h28};
    for (int i = 0; i < 8; i++)
      add_beat(wrap_addr[i], 1'b1, $urandom, 4'hF, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
               0, $urandom_range(0, 2));
    for (int i = 0; i < 8; i++)
      add_beat(wrap_addr[i], 1'b0, 32'h0, 4'h0, (i == 0) ? HTRANS_NONSEQ : HTRANS_SEQ,
               0, $urandom_range(0, 2));
    run_beats(300);

    hburst_i = HBURST_INCR;
    for (int i = 0; i < 60; i++)
      add_beat({26'h0, 4'($urandom), 2'b00}, 1'($urandom), $urandom, 4'($urandom),
               HTRANS_NONSEQ, $urandom_range(0, 2), $urandom_range(0, 3));
    for (int i = 0; i < 16; i++)
      add_beat(32'(i * 4), 1'b0, 32'h0, 4'h0, HTRANS_NONSEQ, 0, $urandom_range(0, 1));
    run_beats(1500);

    // Reset asserted while a read waits in ACCESS must drop psel_o at once.
    hsel_i = 1'b1; htrans_i = HTRANS_NONSEQ; haddr_i = 32'h10; hwrite_i = 1'b0; pready_i = 1'b0;
    @(posedge hclk_i); #1;
    hsel_i = 1'b0; htrans_i = HTRANS_IDLE;
    @(posedge hclk_i); #1;
    check("pre_abort_penable", penable_o, 1'b1);
    hresetn_i = 1'b0;
    #1;
    check("abort_psel", psel_o, 1'b0);
    check("abort_penable", penable_o, 1'b0);
    check("abort_hready", hready_o, 1'b1);
    @(posedge hclk_i); #1;
    hresetn_i = 1'b1;
    last_read = '0;
    repeat (2) @(posedge hclk_i);
    #1;
    add_beat(32'h10, 1'b0, 32'h0, 4'h0, HTRANS_NONSEQ, 0, 1);
    run_beats(50);

`ifdef PSLVERR_EN
    hsel_i = 1'b1; htrans_i = HTRANS_NONSEQ; haddr_i = 32'h04; hwrite_i = 1'b1; pready_i = 1'b1;
    @(posedge hclk_i); #1;
    hsel_i = 1'b0; htrans_i = HTRANS_IDLE; hwdata_i = 32'hCAFE_0001; hwstrb_i = 4'hF;
    @(negedge hclk_i);
    check("err_setup_psel", psel_o, 1'b1);
    @(posedge hclk_i); #1;
    pslverr_i = 1'b1;
    @(negedge hclk_i);
    check("err1_hresp", hresp_o, 1'b1);
    check("err1_hready", hready_o, 1'b0);
    @(posedge hclk_i); #1;
    pslverr_i = 1'b0;
    @(negedge hclk_i);
    check("err2_hresp", hresp_o, 1'b1);
    check("err2_hready", hready_o, 1'b1);
    check("err2_psel", psel_o, 1'b0);
    @(posedge hclk_i); #1;
    @(negedge hclk_i);
    check("err3_hresp", hresp_o, 1'b0);
    check("err3_hready", hready_o, 1'b1);
    @(posedge hclk_i); #1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
